// File: rtl/modmul_interleaved_param.sv
// Radix-2 interleaved (Blakley) modular multiplier: Q = X*Y mod M, one multiplier bit per cycle,
// with per-operation modulus, ready/valid handshakes on both sides and an operand-range error flag.
module modmul_interleaved_param #(
    parameter int W  = 256,
    parameter int CW = $clog2(W)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] Xin,
    input  logic [W-1:0] Yin,
    input  logic [W-1:0] Min,
    output logic [W-1:0] Q,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] CNT_TOP = CW'(W - 1);

    logic [1:0]    state;
    logic [W-1:0]  x_reg;
    logic [W-1:0]  y_reg;
    logic [W-1:0]  m_reg;
    logic [W+1:0]  r_reg;
    logic [CW-1:0] cnt;
    logic [W-1:0]  q_reg;
    logic          err_reg;
    logic          err_pend;

    logic          bad_operands;
    logic [W+1:0]  y_ext;
    logic [W+1:0]  m_ext;
    logic [W+1:0]  t0;
    logic [W+1:0]  t1;
    logic [W+1:0]  t2;

    assign bad_operands = (Min == '0) || (Xin >= Min) || (Yin >= Min);

    // R < M keeps 2R + Y below 3M, so two conditional subtractions restore R < M.
    always_comb begin
        y_ext = {2'b00, y_reg};
        m_ext = {2'b00, m_reg};
        t0    = (r_reg << 1) + (x_reg[cnt] ? y_ext : '0);
        t1    = (t0 >= m_ext) ? (t0 - m_ext) : t0;
        t2    = (t1 >= m_ext) ? (t1 - m_ext) : t1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            x_reg    <= '0;
            y_reg    <= '0;
            m_reg    <= '0;
            r_reg    <= '0;
            cnt      <= '0;
            q_reg    <= '0;
            err_reg  <= 1'b0;
            err_pend <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        x_reg    <= Xin;
                        y_reg    <= Yin;
                        m_reg    <= Min;
                        r_reg    <= '0;
                        cnt      <= CNT_TOP;
                        err_pend <= bad_operands;
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    // A rejected operation spends exactly one RUN cycle, giving its one-cycle latency.
                    if (err_pend) begin
                        q_reg    <= '0;
                        err_reg  <= 1'b1;
                        err_pend <= 1'b0;
                        state    <= S_DONE;
                    end else begin
                        r_reg <= t2;
                        if (cnt == '0) begin
                            q_reg   <= t2[W-1:0];
                            err_reg <= 1'b0;
                            state   <= S_DONE;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign Q         = q_reg;
    assign out_err   = err_reg;

endmodule

// File: tb/tb_modmul_interleaved_param.sv
// Directed bench for modmul_interleaved_param: a W=8 instance driven from a vector table plus
// handshake/reset sequences, and a W=256 instance checked against a wide-integer model.
module tb_modmul_interleaved_param;

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic       in_valid8 = 1'b0;
    logic       in_ready8;
    logic [7:0] xin8 = '0;
    logic [7:0] yin8 = '0;
    logic [7:0] min8 = '0;
    logic [7:0] q8;
    logic       out_valid8;
    logic       out_ready8 = 1'b0;
    logic       out_err8;

    logic         in_valid256 = 1'b0;
    logic         in_ready256;
    logic [255:0] xin256 = '0;
    logic [255:0] yin256 = '0;
    logic [255:0] min256 = '0;
    logic [255:0] q256;
    logic         out_valid256;
    logic         out_ready256 = 1'b0;
    logic         out_err256;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    modmul_interleaved_param #(.W(8)) dut8 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .Xin(xin8), .Yin(yin8), .Min(min8),
        .Q(q8), .out_valid(out_valid8), .out_ready(out_ready8), .out_err(out_err8)
    );

    modmul_interleaved_param #(.W(256)) dut256 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid256), .in_ready(in_ready256),
        .Xin(xin256), .Yin(yin256), .Min(min256),
        .Q(q256), .out_valid(out_valid256), .out_ready(out_ready256), .out_err(out_err256)
    );

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] m;
        logic [7:0] q;
        logic       err;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] golden(input logic [255:0] x, input logic [255:0] y,
                                            input logic [255:0] m);
        logic [511:0] p;
        logic [511:0] r;
        p = {256'b0, x} * {256'b0, y};
        r = p % {256'b0, m};
        return r[255:0];
    endfunction

    task automatic run8(input string name, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] m, input logic [7:0] q, input logic e);
        int n;
        @(negedge clock);
        xin8 = x; yin8 = y; min8 = m; in_valid8 = 1'b1; out_ready8 = 1'b0;
        chk({name, " in_ready idle"}, 256'(in_ready8), 256'd1);
        @(posedge clock); #1;
        in_valid8 = 1'b0;
        n = 0;
        while (!out_valid8 && n < 40) begin
            @(posedge clock); #1;
            n++;
        end
        chk({name, " latency"}, 256'(n), e ? 256'd1 : 256'd8);
        chk({name, " Q"}, 256'(q8), 256'(q));
        chk({name, " out_err"}, 256'(out_err8), 256'(e));
        chk({name, " in_ready done"}, 256'(in_ready8), 256'd0);
        @(negedge clock);
        out_ready8 = 1'b1;
        @(posedge clock); #1;
        chk({name, " out_valid after handoff"}, 256'(out_valid8), 256'd0);
        chk({name, " in_ready after handoff"}, 256'(in_ready8), 256'd1);
        out_ready8 = 1'b0;
    endtask

    task automatic run256(input string name, input logic [255:0] x, input logic [255:0] y,
                          input logic [255:0] m, input logic [255:0] q, input logic e);
        int n;
        @(negedge clock);
        xin256 = x; yin256 = y; min256 = m; in_valid256 = 1'b1; out_ready256 = 1'b0;
        @(posedge clock); #1;
        in_valid256 = 1'b0;
        n = 0;
        while (!out_valid256 && n < 400) begin
            @(posedge clock); #1;
            n++;
        end
        chk({name, " latency"}, 256'(n), e ? 256'd1 : 256'd256);
        chk({name, " Q"}, q256, q);
        chk({name, " out_err"}, 256'(out_err256), 256'(e));
        @(negedge clock);
        out_ready256 = 1'b1;
        @(posedge clock); #1;
        chk({name, " out_valid after handoff"}, 256'(out_valid256), 256'd0);
        out_ready256 = 1'b0;
    endtask

    initial begin
        int n;
        int rises;
        logic [255:0] m256;
        logic [255:0] xa;
        logic [255:0] ya;

        vecs[0]  = '{x: 8'd200, y: 8'd150, m: 8'd251, q: 8'd131, err: 1'b0};
        vecs[1]  = '{x: 8'd250, y: 8'd250, m: 8'd251, q: 8'd1,   err: 1'b0};
        vecs[2]  = '{x: 8'd0,   y: 8'd77,  m: 8'd251, q: 8'd0,   err: 1'b0};
        vecs[3]  = '{x: 8'd251, y: 8'd5,   m: 8'd251, q: 8'd0,   err: 1'b1};
        vecs[4]  = '{x: 8'd3,   y: 8'd4,   m: 8'd0,   q: 8'd0,   err: 1'b1};
        vecs[5]  = '{x: 8'd5,   y: 8'd255, m: 8'd200, q: 8'd0,   err: 1'b1};
        vecs[6]  = '{x: 8'd7,   y: 8'd9,   m: 8'd13,  q: 8'd11,  err: 1'b0};
        vecs[7]  = '{x: 8'd0,   y: 8'd0,   m: 8'd1,   q: 8'd0,   err: 1'b0};
        vecs[8]  = '{x: 8'd254, y: 8'd254, m: 8'd255, q: 8'd1,   err: 1'b0};
        vecs[9]  = '{x: 8'd255, y: 8'd1,   m: 8'd255, q: 8'd0,   err: 1'b1};
        vecs[10] = '{x: 8'd1,   y: 8'd1,   m: 8'd2,   q: 8'd1,   err: 1'b0};

        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("reset in_ready", 256'(in_ready8), 256'd1);
        chk("reset out_valid", 256'(out_valid8), 256'd0);
        chk("reset Q", 256'(q8), 256'd0);
        chk("reset out_err", 256'(out_err8), 256'd0);
        chk("reset in_ready 256", 256'(in_ready256), 256'd1);

        for (int i = 0; i < 11; i++) begin
            run8($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].m, vecs[i].q, vecs[i].err);
        end

        // Back-to-back with in_valid held high and out_ready held high.
        @(negedge clock);
        xin8 = 8'd250; yin8 = 8'd250; min8 = 8'd251; in_valid8 = 1'b1; out_ready8 = 1'b1;
        @(posedge clock); #1;
        chk("b2b first accepted", 256'(in_ready8), 256'd0);
        xin8 = 8'd0; yin8 = 8'd77;
        n = 0;
        while (!out_valid8 && n < 40) begin
            @(posedge clock); #1;
            n++;
        end
        chk("b2b first latency", 256'(n), 256'd8);
        chk("b2b first Q", 256'(q8), 256'd1);
        @(posedge clock); #1;
        chk("b2b handoff out_valid", 256'(out_valid8), 256'd0);
        chk("b2b handoff in_ready", 256'(in_ready8), 256'd1);
        @(posedge clock); #1;
        chk("b2b second accept", 256'(in_ready8), 256'd0);
        n = 0;
        while (!out_valid8 && n < 40) begin
            @(posedge clock); #1;
            n++;
        end
        in_valid8 = 1'b0;
        chk("b2b second latency", 256'(n), 256'd8);
        chk("b2b second Q", 256'(q8), 256'd0);
        @(posedge clock); #1;
        chk("b2b second handoff", 256'(out_valid8), 256'd0);
        out_ready8 = 1'b0;

        // Backpressure: result held while out_ready is low, new in_valid ignored.
        @(negedge clock);
        xin8 = 8'd7; yin8 = 8'd9; min8 = 8'd13; in_valid8 = 1'b1;
        @(posedge clock); #1;
        xin8 = 8'd1; yin8 = 8'd1; min8 = 8'd2;
        n = 0;
        while (!out_valid8 && n < 40) begin
            @(posedge clock); #1;
            n++;
        end
        chk("bp latency", 256'(n), 256'd8);
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            chk($sformatf("bp hold%0d out_valid", i), 256'(out_valid8), 256'd1);
            chk($sformatf("bp hold%0d Q", i), 256'(q8), 256'd11);
            chk($sformatf("bp hold%0d in_ready", i), 256'(in_ready8), 256'd0);
        end
        @(negedge clock);
        in_valid8 = 1'b0; out_ready8 = 1'b1;
        @(posedge clock); #1;
        out_ready8 = 1'b0;
        chk("bp handoff out_valid", 256'(out_valid8), 256'd0);
        chk("bp handoff in_ready", 256'(in_ready8), 256'd1);
        chk("bp Q retained", 256'(q8), 256'd11);

        // Reset asserted three cycles into RUN.
        @(negedge clock);
        xin8 = 8'd200; yin8 = 8'd150; min8 = 8'd251; in_valid8 = 1'b1;
        @(posedge clock); #1;
        in_valid8 = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("midrun reset Q", 256'(q8), 256'd0);
        chk("midrun reset out_valid", 256'(out_valid8), 256'd0);
        chk("midrun reset out_err", 256'(out_err8), 256'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("post reset in_ready", 256'(in_ready8), 256'd1);
        rises = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clock); #1;
            if (out_valid8) rises++;
        end
        chk("no stale result", 256'(rises), 256'd0);
        run8("post reset op", 8'd200, 8'd150, 8'd251, 8'd131, 1'b0);

        // W=256 cases.
        m256 = '1;
        m256 = m256 - 256'd188;
        run256("w256 M-1 times 2", m256 - 256'd1, 256'd2, m256, m256 - 256'd2, 1'b0);
        xa = 256'h972a846916419f828b9d2434e465e150bd9c66b3ad3c2d6d1a3d1fa7bc8960a9;
        ya = 256'h9a1de644815ef6d13b8faa1837f8a88b17fc695a07a0ca6e0822e8f36c031199;
        run256("w256 random", xa, ya, m256, golden(xa, ya, m256), 1'b0);
        run256("w256 all ones X", '1, 256'd3, m256, 256'd0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
